multi_region_profiler: RTL

MULTI_REGION_PROFILER -- requirements
Module: multi_region_profiler

---
 rtl/multi_region_profiler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/multi_region_profiler.sv
// Multi-region PC profiler: two-stage trace pipeline, per-region hit counters with
// saturation, snapshot shadows. Define PROF_IRQ_EN to add a registered saturation irq.
module multi_region_profiler #(
  parameter int NUM_REGIONS = 4,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [0:31]            P_Trace_PC,
  input  logic                   P_Trace_Valid_Instr,
  input  logic                   prof_run,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_idx,
  input  logic [31:0]            cfg_lo,
  input  logic [31:0]            cfg_hi,
  input  logic                   cfg_en,
  input  logic                   clr,
  input  logic                   snap,
  input  logic [2:0]             rd_idx,
  output logic [CNT_W-1:0]       rd_count,
  output logic [NUM_REGIONS-1:0] sat,
  output logic                   snap_done
`ifdef PROF_IRQ_EN
  ,
  output logic                   irq
`endif
);

  logic [31:0]            pc_s1;
  logic                   vld_s1;
  logic [NUM_REGIONS-1:0] hit_c;
  logic [NUM_REGIONS-1:0] hit_s2;
  logic [31:0]            lo     [NUM_REGIONS];
  logic [31:0]            hi     [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] en;
  logic [CNT_W-1:0]       cnt    [NUM_REGIONS];
  logic [CNT_W-1:0]       shadow [NUM_REGIONS];

  // Bit 0 of the trace PC is its MSB, so a plain copy keeps the numeric value.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      pc_s1  <= '0;
      vld_s1 <= 1'b0;
    end else begin
      pc_s1  <= P_Trace_PC;
      vld_s1 <= P_Trace_Valid_Instr & prof_run;
    end
  end

  always_comb begin
    hit_c = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit_c[i] = vld_s1 && en[i] && (pc_s1 >= lo[i]) && (pc_s1 <= hi[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      hit_s2 <= '0;
    end else begin
      hit_s2 <= hit_c;
    end
  end

  // Index decode by equality so out-of-range cfg_idx values never alias onto a region.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        lo[i] <= '0;
        hi[i] <= '0;
      end
      en <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (cfg_idx == 3'(i)) begin
          lo[i] <= cfg_lo;
          hi[i] <= cfg_hi;
          en[i] <= cfg_en;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        cnt[i] <= '0;
      end
      sat <= '0;
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (hit_s2[i]) begin
          if (cnt[i] == {CNT_W{1'b1}}) begin
            sat[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Shadows capture the pre-edge live value, so a same-edge clr or increment is not seen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        shadow[i] <= '0;
      end
      snap_done <= 1'b0;
    end else begin
      if (snap) begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
          shadow[i] <= cnt[i];
        end
      end
      snap_done <= snap;
    end
  end

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (rd_idx == 3'(i)) begin
        rd_count = shadow[i];
      end
    end
  end

`ifdef PROF_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      irq <= 1'b0;
    end else begin
      irq <= |sat;
    end
  end
`endif

endmodule
